// File: rtl/csr_if.sv
// CSR access, trap/mret and retirement signals between the core pipeline and csr_unit.
interface csr_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic            mret_valid;
  logic            instret_inc;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mret_target;
  logic            mie_out;

  modport master (
    output csr_addr, csr_op, csr_wdata, trap_valid, trap_pc, trap_cause,
           mret_valid, instret_inc,
    input  csr_rdata, csr_illegal, trap_target, mret_target, mie_out
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata, trap_valid, trap_pc, trap_cause,
           mret_valid, instret_inc,
    output csr_rdata, csr_illegal, trap_target, mret_target, mie_out
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: Zicsr RW/RS/RC, trap entry / mret updates, mcycle/minstret,
// WARL legalisation and illegal-access detection.
module csr_unit #(
  parameter int unsigned    XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic clk,
  input  logic rst,
  csr_if.slave bus
);

  localparam logic [1:0]  OP_NONE = 2'b00;
  localparam logic [1:0]  OP_RW   = 2'b01;
  localparam logic [1:0]  OP_RS   = 2'b10;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mcycle, minstret;

  logic            mie_n, mpie_n;
  logic [XLEN-1:0] mtvec_n, mscratch_n, mepc_n, mcause_n, mcycle_n, minstret_n;

  logic            implemented, read_only;
  logic [XLEN-1:0] rdata, wval, mstatus_rd, tvec_base;
  logic            write_req, illegal, wen;

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie;
    mstatus_rd[3]     = mie;
  end

  // Address decode and pre-write read value.
  always_comb begin
    implemented = 1'b1;
    read_only   = 1'b0;
    rdata       = '0;
    unique case (bus.csr_addr)
      A_MSTATUS:  rdata = mstatus_rd;
      A_MTVEC:    rdata = mtvec;
      A_MSCRATCH: rdata = mscratch;
      A_MEPC:     rdata = mepc;
      A_MCAUSE:   rdata = mcause;
      A_MCYCLE:   rdata = mcycle;
      A_MINSTRET: rdata = minstret;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: read_only = 1'b1;
      default:    implemented = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never counts as a write.
  always_comb begin
    unique case (bus.csr_op)
      OP_RW:   wval = bus.csr_wdata;
      OP_RS:   wval = rdata | bus.csr_wdata;
      default: wval = rdata & ~bus.csr_wdata;
    endcase
    write_req = (bus.csr_op == OP_RW) || (bus.csr_op != OP_NONE && bus.csr_wdata != '0);
    illegal   = (bus.csr_op != OP_NONE) && (!implemented || (read_only && write_req));
    wen       = write_req && !illegal && !bus.trap_valid && !bus.mret_valid;
  end

  // Next-state: trap beats mret beats CSR write; counters tick unless overwritten.
  always_comb begin
    mie_n      = mie;
    mpie_n     = mpie;
    mtvec_n    = mtvec;
    mscratch_n = mscratch;
    mepc_n     = mepc;
    mcause_n   = mcause;
    mcycle_n   = mcycle + XLEN'(1);
    minstret_n = minstret + XLEN'(bus.instret_inc);
    if (bus.trap_valid) begin
      mepc_n   = {bus.trap_pc[XLEN-1:2], 2'b00};
      mcause_n = bus.trap_cause;
      mpie_n   = mie;
      mie_n    = 1'b0;
    end else if (bus.mret_valid) begin
      mie_n  = mpie;
      mpie_n = 1'b1;
    end else if (wen) begin
      unique case (bus.csr_addr)
        A_MSTATUS: begin
          mie_n  = wval[3];
          mpie_n = wval[7];
        end
        A_MTVEC:    mtvec_n    = {wval[XLEN-1:2], 1'b0, wval[0]};
        A_MSCRATCH: mscratch_n = wval;
        A_MEPC:     mepc_n     = {wval[XLEN-1:2], 2'b00};
        A_MCAUSE:   mcause_n   = wval;
        A_MCYCLE:   mcycle_n   = wval;
        A_MINSTRET: minstret_n = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= RESET_MTVEC;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mie      <= mie_n;
      mpie     <= mpie_n;
      mtvec    <= mtvec_n;
      mscratch <= mscratch_n;
      mepc     <= mepc_n;
      mcause   <= mcause_n;
      mcycle   <= mcycle_n;
      minstret <= minstret_n;
    end
  end

  // Vectored interrupts offset by 4*cause; the shift drops the top cause bits on purpose.
  assign tvec_base       = {mtvec[XLEN-1:2], 2'b00};
  assign bus.trap_target = (mtvec[0] && bus.trap_cause[XLEN-1])
                         ? tvec_base + {bus.trap_cause[XLEN-3:0], 2'b00}
                         : tvec_base;

  assign bus.csr_rdata   = rdata;
  assign bus.csr_illegal = illegal;
  assign bus.mret_target = mepc;
  assign bus.mie_out     = mie;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed test-plan sequences plus random traffic, all checked
// cycle by cycle against a word-level model of the machine CSRs.
module tb_csr_unit;

  localparam int unsigned XLEN        = 64;
  localparam logic [63:0] RESET_MTVEC = 64'h0000_0000_0000_4000;

  logic clk;
  logic rst;
  csr_if #(.XLEN(XLEN)) bus ();

  csr_unit #(.XLEN(XLEN), .RESET_MTVEC(RESET_MTVEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mstatus kept as the full architectural word.
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;
  logic [63:0] got_rdata;
  logic        got_ill;
  logic [63:0] got_tt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_implemented(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                     [12'hF11:12'hF14]};
  endfunction

  function automatic logic m_illegal(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
    logic writes;
    writes = (op == 2'd1) || (op != 2'd0 && wd != 64'd0);
    return op != 2'd0 && (!m_implemented(a) || (a inside {[12'hF11:12'hF14]} && writes));
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_target(input logic [63:0] cause);
    logic [63:0] base;
    base = m_mtvec & ~64'd3;
    if (m_mtvec[0] && cause[63]) return base + 64'd4 * (cause & ~(64'd1 << 63));
    return base;
  endfunction

  task automatic m_reset();
    m_mstatus = 64'h1800; m_mtvec = RESET_MTVEC; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mcycle = 0; m_minstret = 0;
  endtask

  task automatic m_step(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                        input logic tv, input logic [63:0] pc, input logic [63:0] cause,
                        input logic mv, input logic inc);
    logic [63:0] old, wv, nxt_cycle, nxt_instret;
    logic        does_write, mie, mpie;
    old  = m_read(a);
    mie  = m_mstatus[3];
    mpie = m_mstatus[7];
    wv   = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
    does_write = op != 0 && !m_illegal(a, op, wd) && (op == 2'd1 || wd != 0) && !tv && !mv;
    nxt_cycle   = m_mcycle + 1;
    nxt_instret = m_minstret + (inc ? 64'd1 : 64'd0);
    if (tv) begin
      m_mepc    = pc & ~64'd3;
      m_mcause  = cause;
      m_mstatus = 64'h1800 | (mie ? 64'h80 : 64'h0);
    end else if (mv) begin
      m_mstatus = 64'h1880 | (mpie ? 64'h8 : 64'h0);
    end else if (does_write) begin
      case (a)
        12'h300: m_mstatus  = 64'h1800 | (wv & 64'h88);
        12'h305: m_mtvec    = wv & ~64'd2;
        12'h340: m_mscratch = wv;
        12'h341: m_mepc     = wv & ~64'd3;
        12'h342: m_mcause   = wv;
        12'hB00: nxt_cycle   = wv;
        12'hB02: nxt_instret = wv;
        default: ;
      endcase
    end
    m_mcycle   = nxt_cycle;
    m_minstret = nxt_instret;
  endtask

  // One clock: drive, compare combinational/registered outputs at negedge, advance model.
  task automatic step(input logic r, input logic [11:0] a, input logic [1:0] op,
                      input logic [63:0] wd, input logic tv, input logic [63:0] pc,
                      input logic [63:0] cause, input logic mv, input logic inc);
    rst = r;
    bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
    bus.trap_valid = tv; bus.trap_pc = pc; bus.trap_cause = cause;
    bus.mret_valid = mv; bus.instret_inc = inc;
    @(negedge clk);
    got_rdata = bus.csr_rdata;
    got_ill   = bus.csr_illegal;
    got_tt    = bus.trap_target;
    if (!r) begin
      check("rdata", got_rdata, m_read(a));
      check("illegal", 64'(got_ill), 64'(m_illegal(a, op, wd)));
      check("trap_target", got_tt, m_target(cause));
      check("mret_target", bus.mret_target, m_mepc);
      check("mie_out", 64'(bus.mie_out), 64'(m_mstatus[3]));
    end
    if (r) m_reset();
    else   m_step(a, op, wd, tv, pc, cause, mv, inc);
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
    step(1'b0, a, op, wd, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [11:0] a);
    acc(a, 2'd0, 64'd0);
  endtask

  logic [11:0] addr_pool [12];

  initial begin
    addr_pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                  12'hB02, 12'hF11, 12'hF14, 12'hF15, 12'h123, 12'h344};
    m_reset();
    step(1'b1, 12'h0, 2'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 12'h0, 2'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

    // Reset values and mcycle counting from 0.
    rd(12'hB00); check("mcycle0", got_rdata, 64'd0);
    rd(12'hB00); check("mcycle1", got_rdata, 64'd1);
    rd(12'hB00); check("mcycle2", got_rdata, 64'd2);
    rd(12'h300); check("mstatus_rst", got_rdata, 64'h1800);
    rd(12'h305); check("mtvec_rst", got_rdata, RESET_MTVEC);
    rd(12'h340); rd(12'h341); rd(12'h342); rd(12'hB02);

    // mscratch RW/RS/RC.
    acc(12'h340, 2'd1, 64'hDEAD_BEEF);
    rd(12'h340); check("rw", got_rdata, 64'hDEAD_BEEF);
    acc(12'h340, 2'd2, 64'hF000_0000);
    rd(12'h340); check("rs", got_rdata, 64'hFEAD_BEEF);
    acc(12'h340, 2'd3, 64'hF);
    rd(12'h340); check("rc", got_rdata, 64'hFEAD_BEE0);

    // Read-only range.
    acc(12'hF11, 2'd2, 64'd0); check("ro_rs0_legal", 64'(got_ill), 64'd0);
    acc(12'hF11, 2'd1, 64'h55); check("ro_rw_illegal", 64'(got_ill), 64'd1);
    rd(12'hF11); check("ro_reads0", got_rdata, 64'd0);

    // Vectored interrupt entry and mret.
    acc(12'h305, 2'd1, 64'h8000_0001);
    acc(12'h300, 2'd1, 64'h8);
    step(1'b0, 12'h0, 2'd0, 64'd0, 1'b1, 64'h8000_0102, 64'h8000_0000_0000_0007, 1'b0, 1'b0);
    check("vec_target", got_tt, 64'h8000_001C);
    rd(12'h341); check("trap_mepc", got_rdata, 64'h8000_0100);
    rd(12'h300); check("trap_mstatus", got_rdata, 64'h1880);
    step(1'b0, 12'h0, 2'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    rd(12'h300); check("mret_mstatus", got_rdata, 64'h1888);

    // Priority: trap beats mret and CSR write; mret beats CSR write.
    step(1'b0, 12'h340, 2'd1, 64'h1234, 1'b1, 64'h2000, 64'd2, 1'b1, 1'b0);
    rd(12'h340); check("trap_drops_wr", got_rdata, 64'hFEAD_BEE0);
    rd(12'h342); check("trap_cause", got_rdata, 64'd2);
    step(1'b0, 12'h341, 2'd1, 64'h444, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    rd(12'h341); check("mret_drops_wr", got_rdata, 64'h2000);

    // Counter override and wrap.
    acc(12'hB00, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(12'hB00); check("mcycle_wr", got_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(12'hB00); check("mcycle_max", got_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00); check("mcycle_wrap", got_rdata, 64'd0);
    step(1'b0, 12'hB02, 2'd1, 64'd5, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 12'hB02, 2'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("minstret_wr", got_rdata, 64'd5);
    rd(12'hB02); check("minstret_inc", got_rdata, 64'd6);

    // WARL fields.
    acc(12'h305, 2'd1, 64'h1003);
    rd(12'h305); check("warl_mtvec", got_rdata, 64'h1001);
    acc(12'h341, 2'd1, 64'h123);
    rd(12'h341); check("warl_mepc", got_rdata, 64'h120);
    acc(12'h300, 2'd1, '1);
    rd(12'h300); check("warl_mstatus", got_rdata, 64'h1888);

    // Reset overrides a concurrent trap and write.
    step(1'b1, 12'h340, 2'd1, 64'h99, 1'b1, 64'h40, 64'd3, 1'b0, 1'b1);
    rd(12'hB00); check("rst_mcycle", got_rdata, 64'd0);
    rd(12'h300); check("rst_mstatus", got_rdata, 64'h1800);
    rd(12'h340); check("rst_mscratch", got_rdata, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] wd, pc, cause;
      wd    = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      pc    = {$urandom, $urandom};
      cause = {1'($urandom_range(0, 1)), 59'd0, 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) cause = {$urandom, $urandom};
      step(1'b0, addr_pool[$urandom_range(0, 11)], 2'($urandom_range(0, 3)), wd,
           $urandom_range(0, 19) == 0, pc, cause, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
